ram_write_buffer: RTL and testbench
===================================

// Module: ram_write_buffer
// PURPOSE
//   Posted write-through buffer between the cache controller's RAM port (upstream, ctrl_*) and the RAM (downstream, mem_*).
//   Writes are acknowledged as soon as they enter a FIFO and drain to RAM in the background.
//   Reads check the FIFO first (youngest matching entry is forwarded); otherwise they go to RAM, ahead of pending drains.
//   Both ports use the same enable/ready protocol as the RAM, so the block drops in without changing the controller.
// PARAMETERS
//   ADDR_WIDTH  16  address width
//   DATA_WIDTH  32  data width
//   DEPTH       4   number of FIFO entries, power of two
//   PTR_WIDTH   2   log2(DEPTH)
// PORTS
//   clk               in   1           clock; all state updates on posedge
//   rst               in   1           asynchronous reset, active-high
//   ctrl_address      in   ADDR_WIDTH  upstream request address
//   ctrl_write_data   in   DATA_WIDTH  upstream write data
//   ctrl_read_enable  in   1           upstream read request, held high until ctrl_ready
//   ctrl_write_enable in   1           upstream write request, held high until ctrl_ready
//   ctrl_read_data    out  DATA_WIDTH  read result; valid while ctrl_ready=1
//   ctrl_ready        out  1           one-cycle completion pulse
//   mem_address       out  ADDR_WIDTH  RAM address
//   mem_write_data    out  DATA_WIDTH  RAM write data
//   mem_read_enable   out  1           one-cycle RAM read pulse
//   mem_write_enable  out  1           one-cycle RAM write pulse
//   mem_read_data     in   DATA_WIDTH  RAM read data; valid with mem_ready
//   mem_ready         in   1           RAM completion pulse
//   wb_count          out  PTR_WIDTH+1 number of occupied entries (0..DEPTH)
//   wb_empty          out  1           wb_count==0 (combinational)
// BEHAVIOUR
//   Reset (async): all outputs 0; FIFO pointers and count 0; FSM in IDLE. Buffered writes are discarded.
//   Reset mid-drain: the in-flight write is abandoned; a mem_ready arriving after reset is ignored.
//   New-request rule: an enable is a new request only if sampled while ctrl_ready=0 and no upstream read is outstanding.
//     An enable sampled while ctrl_ready=1 is the controller's trailing cycle and is ignored.
//   Both enables high: illegal; handled as a write, the read is ignored.
//   Write accept: FIFO not full -> push {addr,data} at that edge; ctrl_ready=1 on the next cycle (latency 1).
//     FIFO full -> no accept and no ctrl_ready. Retried every cycle; accepted on the edge after the pop that frees a slot.
//   Read, forward hit (any valid entry with equal address, the in-flight head included):
//     ctrl_read_data = youngest match; ctrl_ready next cycle (latency 1); RAM untouched.
//   Read, forward miss: upstream marked busy. When the mem FSM is IDLE, pulse mem_read_enable, go to RD_WAIT.
//     On mem_ready: ctrl_read_data<=mem_read_data, ctrl_ready<=1, back to IDLE.
//   Mem FSM IDLE->RD_WAIT: a pending read miss has priority.
//   Mem FSM IDLE->WR_WAIT: no pending read and count>0; pulse mem_write_enable with the head entry.
//   Mem FSM RD_WAIT/WR_WAIT->IDLE: on mem_ready. In WR_WAIT this pops the head.
//   One RAM op outstanding at a time; a mem_ready in IDLE is ignored.
//   Push and pop on the same edge: count unchanged, both pointers advance.
//   Pointers wrap modulo DEPTH.
//   Drained entries can be overtaken only by reads to addresses not in the FIFO, so ordering is safe.
//   ctrl_ready and mem enables never stay high for two consecutive cycles.
// CONFIGURATION
//   WB_COALESCE_EN defined:
//     A write whose address matches a valid non-head entry (or the head while not in flight) overwrites that entry's data.
//     No push; ctrl_ready next cycle, even when the FIFO is full.
//     A match only on the in-flight head allocates a new entry.
//   WB_COALESCE_EN undefined: every write allocates an entry; duplicate addresses coexist, the youngest is forwarded.
// TESTING
//   1 Write 0x0010<=0xDEAD0001 -> ctrl_ready 1 cycle later; read 0x0010 right away -> 0xDEAD0001 forwarded, no mem_read_enable.
//   2 Four writes to 0x0100..0x0103 with a stalled mem model -> wb_count=4; a fifth write gets no ctrl_ready until the first mem_ready, then completes; RAM holds all five in order.
//   3 Read 0x0005 with FIFO holding 3 entries, mem model value 50 -> mem_read_enable issued before the next drain; ctrl_read_data=50.
//   4 Write 0x0020<=1 then 0x0020<=2 -> forwarded read returns 2.
//      With WB_COALESCE_EN: wb_count=1 and one RAM write. Without it: wb_count=2 and two RAM writes, final RAM value 2.
//   5 Controller-style held enable (high the cycle ctrl_ready is seen) -> exactly one push per write, no duplicate RAM write.
//   6 Assert rst during WR_WAIT with 2 entries -> outputs 0 and wb_count=0 immediately; the late mem_ready is ignored.

Source files
------------

// File: rtl/ram_write_buffer.sv
// Posted write buffer between the cache controller and RAM: writes complete on entry, drain in background,
// reads forward the youngest buffered match. Optional write coalescing is enabled by defining WB_COALESCE_EN.
module ram_write_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ctrl_address,
  input  logic [DATA_WIDTH-1:0] ctrl_write_data,
  input  logic                  ctrl_read_enable,
  input  logic                  ctrl_write_enable,
  output logic [DATA_WIDTH-1:0] ctrl_read_data,
  output logic                  ctrl_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ready,
  output logic [PTR_WIDTH:0]    wb_count,
  output logic                  wb_empty
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  mem_state_e            state_q, state_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  ctrl_ready_q, ctrl_ready_d;
  logic [DATA_WIDTH-1:0] ctrl_rdata_q, ctrl_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

  logic [DEPTH-1:0]      slot_match;
  logic                  fwd_hit;
  logic [PTR_WIDTH-1:0]  hit_idx;
  logic                  new_req, wr_req, rd_req, rd_miss;
  logic                  coal_hit, wr_accept, push, pop, coal_write;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign slot_match[gi] = (fifo_addr_q[gi] == ctrl_address);
  end

  // Walk from oldest to youngest so the last valid match wins.
  always_comb begin
    fwd_hit = 1'b0;
    hit_idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PTR_WIDTH+1)'(k) < count_q) && slot_match[rd_ptr_q + PTR_WIDTH'(k)]) begin
        fwd_hit = 1'b1;
        hit_idx = rd_ptr_q + PTR_WIDTH'(k);
      end
    end
  end

  // Enables seen during the ready cycle or behind an outstanding read are not new requests.
  assign new_req = !ctrl_ready_q && !rd_pending_q;
  assign wr_req  = new_req && ctrl_write_enable;
  assign rd_req  = new_req && ctrl_read_enable && !ctrl_write_enable;
  assign rd_miss = rd_req && !fwd_hit;

`ifdef WB_COALESCE_EN
  // The youngest match is the only candidate; if it is the head already on the bus, allocate instead.
  assign coal_hit = fwd_hit && !((hit_idx == rd_ptr_q) && (state_q == WR_WAIT));
`else
  assign coal_hit = 1'b0;
`endif

  assign wr_accept  = wr_req && (coal_hit || (count_q != FULL_COUNT));
  assign push       = wr_accept && !coal_hit;
  assign coal_write = wr_accept && coal_hit;
  assign pop        = (state_q == WR_WAIT) && mem_ready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    ctrl_ready_d = 1'b0;
    ctrl_rdata_d = ctrl_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;

    if (wr_accept) begin
      ctrl_ready_d = 1'b1;
    end
    if (rd_req && fwd_hit) begin
      ctrl_ready_d = 1'b1;
      ctrl_rdata_d = fifo_data_q[hit_idx];
    end
    if (rd_miss) begin
      rd_pending_d = 1'b1;
      rd_addr_d    = ctrl_address;
    end

    case (state_q)
      IDLE: begin
        if (rd_pending_q || rd_miss) begin
          mem_re_d   = 1'b1;
          mem_addr_d = rd_pending_q ? rd_addr_q : ctrl_address;
          state_d    = RD_WAIT;
        end else if (count_q != '0) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          // A head being coalesced on this very edge must leave with the merged data.
          mem_wdata_d = (coal_write && (hit_idx == rd_ptr_q)) ? ctrl_write_data
                                                              : fifo_data_q[rd_ptr_q];
          state_d     = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ready) begin
          ctrl_rdata_d = mem_read_data;
          ctrl_ready_d = 1'b1;
          rd_pending_d = 1'b0;
          state_d      = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      ctrl_ready_q <= 1'b0;
      ctrl_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      ctrl_ready_q <= ctrl_ready_d;
      ctrl_rdata_q <= ctrl_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Entry storage needs no reset: occupancy is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ctrl_address;
      fifo_data_q[wr_ptr_q] <= ctrl_write_data;
    end else if (coal_write) begin
      fifo_data_q[hit_idx] <= ctrl_write_data;
    end
  end

  assign ctrl_read_data   = ctrl_rdata_q;
  assign ctrl_ready       = ctrl_ready_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign wb_count         = count_q;
  assign wb_empty         = (count_q == '0);

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed scenarios plus random traffic for ram_write_buffer, checked against a flat memory that applies
// every acknowledged write at once. Expectations for WB_COALESCE_EN builds follow the same macro.
`timescale 1ns/1ps
module tb_ram_write_buffer;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int PW = 2;

`ifdef WB_COALESCE_EN
  localparam int T4_COUNT  = 2;
  localparam int T4_WRITES = 1;
`else
  localparam int T4_COUNT  = 3;
  localparam int T4_WRITES = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ctrl_address = '0;
  logic [DW-1:0] ctrl_write_data = '0;
  logic          ctrl_read_enable = 1'b0;
  logic          ctrl_write_enable = 1'b0;
  logic [DW-1:0] ctrl_read_data;
  logic          ctrl_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_ready;
  logic [PW:0]   wb_count;
  logic          wb_empty;

  logic resp_ready = 1'b0;
  logic inj_ready  = 1'b0;
  assign mem_ready = resp_ready | inj_ready;

  ram_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .ctrl_address(ctrl_address), .ctrl_write_data(ctrl_write_data),
    .ctrl_read_enable(ctrl_read_enable), .ctrl_write_enable(ctrl_write_enable),
    .ctrl_read_data(ctrl_read_data), .ctrl_ready(ctrl_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Background RAM contents for never-written addresses.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 16'h0005) ? 32'd50 : {16'hA5A5, a};
  endfunction

  // RAM model and protocol monitor; all state here is owned by this process.
  logic [DW-1:0]    ram [int];
  logic [AW+DW-1:0] write_log [$];
  int               op_log [$];
  int               mem_ops = 0;
  int               mem_rd_ops = 0;
  int               cyc = 0;
  bit               busy = 1'b0;
  bit               busy_rd = 1'b0;
  logic [AW-1:0]    busy_addr = '0;
  int               lat_cnt = 0;
  bit               proto_viol = 1'b0;
  bit               prev_rdy = 1'b0, prev_re = 1'b0, prev_we = 1'b0;

  bit stall_hold = 1'b0;
  int stall_release = 0;
  int resp_lat = 0;

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram.exists(int'(a)) ? ram[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin
    cyc++;
    resp_ready = 1'b0;
    if ((ctrl_ready && prev_rdy) || (mem_read_enable && prev_re) || (mem_write_enable && prev_we))
      proto_viol = 1'b1;
    prev_rdy = ctrl_ready;
    prev_re  = mem_read_enable;
    prev_we  = mem_write_enable;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if ((mem_read_enable || mem_write_enable) && (busy || (mem_read_enable && mem_write_enable)))
        proto_viol = 1'b1;
      if (busy) begin
        if (!(stall_hold || (cyc < stall_release))) begin
          if (lat_cnt == 0) begin
            resp_ready = 1'b1;
            if (busy_rd) mem_read_data = ram_rd(busy_addr);
            busy = 1'b0;
          end else begin
            lat_cnt--;
          end
        end
      end else if (mem_write_enable) begin
        ram[int'(mem_address)] = mem_write_data;
        write_log.push_back({mem_address, mem_write_data});
        op_log.push_back(0);
        mem_ops++;
        busy = 1'b1; busy_rd = 1'b0; lat_cnt = resp_lat;
      end else if (mem_read_enable) begin
        op_log.push_back(1);
        mem_ops++;
        mem_rd_ops++;
        busy = 1'b1; busy_rd = 1'b1; busy_addr = mem_address; lat_cnt = resp_lat;
      end
    end
  end

  // Controller-style request: enable held until ctrl_ready is seen, and through that ready cycle.
  task automatic do_op(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output int lat);
    ctrl_address      = a;
    ctrl_write_data   = d;
    ctrl_write_enable = is_wr;
    ctrl_read_enable  = !is_wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ctrl_ready && lat < 200);
    if (!ctrl_ready) lat = -1;
    rd = ctrl_read_data;
    @(negedge clk);
    ctrl_write_enable = 1'b0;
    ctrl_read_enable  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((!wb_empty || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 500), 1);
    repeat (2) @(negedge clk);
  endtask

  logic [DW-1:0] refm [int];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return refm.exists(int'(a)) ? refm[int'(a)] : init_val(a);
  endfunction

  initial begin
    logic [DW-1:0] rd;
    int            lat, n0, base, cnt, nwr, op1;
    bit            seen, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {ctrl_ready, ctrl_read_data}, 0);
    check("reset_mem", {mem_read_enable, mem_write_enable, mem_address}, 0);
    check("reset_wdata", mem_write_data, 0);
    check("reset_count", {wb_count, wb_empty}, 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: write then immediate forwarded read
    stall_hold = 1'b1; resp_lat = 0;
    base = write_log.size();
    do_op(1'b1, 16'h0010, 32'hDEAD0001, rd, lat);
    $display("txn T1 WR addr=0010 data=DEAD0001 lat=%0d", lat);
    check("t1_wr_lat", lat, 1);
    n0 = mem_rd_ops;
    do_op(1'b0, 16'h0010, '0, rd, lat);
    $display("txn T1 RD addr=0010 data=%h lat=%0d", rd, lat);
    check("t1_fwd_data", rd, 32'hDEAD0001);
    check("t1_fwd_lat", lat, 1);
    check("t1_no_mem_read", mem_rd_ops, n0);
    stall_hold = 1'b0;
    wait_drain("t1_drain");
    check("t1_ram_writes", write_log.size() - base, 1);
    check("t1_ram_value", ram_rd(16'h0010), 32'hDEAD0001);

    // 2: fill the FIFO behind a stalled RAM, fifth write waits for the first pop
    stall_hold = 1'b1;
    base = write_log.size();
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, AW'(16'h0100 + i), DW'(32'h1000 + i), rd, lat);
      $display("txn T2 WR addr=%h lat=%0d", AW'(16'h0100 + i), lat);
      check("t2_wr_lat", lat, 1);
    end
    check("t2_count_full", wb_count, 4);
    ctrl_address = 16'h0104; ctrl_write_data = 32'h1004; ctrl_write_enable = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ctrl_ready) seen = 1'b1;
    end
    check("t2_full_no_ready", seen, 0);
    stall_hold = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ctrl_ready && lat < 50);
    $display("txn T2 WR addr=0104 extra_lat=%0d", lat);
    check("t2_fifth_done", ctrl_ready, 1);
    @(negedge clk);
    ctrl_write_enable = 1'b0;
    wait_drain("t2_drain");
    check("t2_ram_writes", write_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      check("t2_ram_order", ((base + i) < write_log.size()) ? write_log[base + i] : '0,
            {AW'(16'h0100 + i), DW'(32'h1000 + i)});
    end

    // 3: read miss overtakes pending drains
    stall_hold = 1'b1;
    base = op_log.size();
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, AW'(16'h0200 + i), DW'(32'h2000 + i), rd, lat);
      $display("txn T3 WR addr=%h lat=%0d", AW'(16'h0200 + i), lat);
    end
    n0 = mem_rd_ops;
    stall_hold = 1'b0;
    stall_release = cyc + 5;
    do_op(1'b0, 16'h0005, '0, rd, lat);
    $display("txn T3 RD addr=0005 data=%0d lat=%0d", rd, lat);
    check("t3_miss_data", rd, 50);
    check("t3_mem_read_issued", mem_rd_ops - n0, 1);
    op1 = ((base + 1) < op_log.size()) ? op_log[base + 1] : 2;
    check("t3_read_before_drain", op1, 1);
    wait_drain("t3_drain");
    check("t3_ram_tail", ram_rd(16'h0202), 32'h2002);

    // 4: two writes to one address
    stall_hold = 1'b1;
    base = write_log.size();
    do_op(1'b1, 16'h0030, 32'd9, rd, lat);
    do_op(1'b1, 16'h0020, 32'd1, rd, lat);
    do_op(1'b1, 16'h0020, 32'd2, rd, lat);
    $display("txn T4 WR addr=0020 data=2 lat=%0d", lat);
    check("t4_count", wb_count, T4_COUNT);
    do_op(1'b0, 16'h0020, '0, rd, lat);
    $display("txn T4 RD addr=0020 data=%0d lat=%0d", rd, lat);
    check("t4_fwd_youngest", rd, 2);
    check("t4_fwd_lat", lat, 1);
    stall_hold = 1'b0;
    wait_drain("t4_drain");
    cnt = 0;
    for (int j = base; j < write_log.size(); j++) begin
      if (write_log[j][AW+DW-1:DW] == 16'h0020) cnt++;
    end
    check("t4_ram_writes_0020", cnt, T4_WRITES);
    check("t4_ram_value", ram_rd(16'h0020), 2);

    // 6: reset while a drain is in flight
    stall_hold = 1'b1;
    do_op(1'b1, 16'h0300, 32'h3000, rd, lat);
    do_op(1'b1, 16'h0301, 32'h3001, rd, lat);
    check("t6_count_before", wb_count, 2);
    check("t6_inflight_addr", mem_address, 16'h0300);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {ctrl_ready, ctrl_read_data}, 0);
    check("t6_rst_mem", {mem_read_enable, mem_write_enable, mem_address}, 0);
    check("t6_rst_wdata", mem_write_data, 0);
    check("t6_rst_count", {wb_count, wb_empty}, 1);
    @(negedge clk);
    rst = 1'b0;
    stall_hold = 1'b0;
    n0 = mem_ops;
    @(negedge clk);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_late_ready_ignored", mem_ops - n0, 0);
    check("t6_count_after", wb_count, 0);
    do_op(1'b1, 16'h0400, 32'd77, rd, lat);
    check("t6_wr_after_rst", lat, 1);
    do_op(1'b0, 16'h0400, '0, rd, lat);
    $display("txn T6 RD addr=0400 data=%0d lat=%0d", rd, lat);
    check("t6_rd_after_rst", rd, 77);
    wait_drain("t6_drain");

    // Random traffic on a small address window
    base = write_log.size();
    nwr = 0;
    for (int t = 0; t < 160; t++) begin
      w = ($urandom_range(0, 9) < 6);
      a = AW'(32'h0040 + $urandom_range(0, 7));
      d = $urandom;
      resp_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) stall_release = cyc + $urandom_range(1, 10);
      do_op(w, a, d, rd, lat);
      if (w) begin
        refm[int'(a)] = d;
        nwr++;
        $display("txn %0d WR addr=%h data=%h lat=%0d", t, a, d, lat);
        check("rand_wr_done", (lat > 0), 1);
      end else begin
        $display("txn %0d RD addr=%h data=%h lat=%0d", t, a, rd, lat);
        check("rand_rd_done", (lat > 0), 1);
        check("rand_rd_data", rd, ref_rd(a));
      end
    end
    wait_drain("rand_drain");
    for (int i = 0; i < 8; i++) begin
      check("rand_ram_final", ram_rd(AW'(16'h0040 + i)), ref_rd(AW'(16'h0040 + i)));
    end
`ifdef WB_COALESCE_EN
    check("rand_ram_write_count", ((write_log.size() - base) <= nwr), 1);
`else
    check("rand_ram_write_count", write_log.size() - base, nwr);
`endif
    check("protocol_pulses", proto_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
